// File: rtl/prog_counter_if.sv
// Control/status bundle between the CPU timer logic and the programmable event counter.
interface prog_counter_if #(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 8
);
   logic                  en;
   logic                  clr;
   logic                  load;
   logic [WIDTH-1:0]      load_val;
   logic                  start;
   logic                  dir;
   logic [1:0]            mode;
   logic [WIDTH-1:0]      limit;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      out;
   logic                  tc;
   logic                  done;
   logic                  busy;

   modport master (
      output en, clr, load, load_val, start, dir, mode, limit, prescale,
      input  out, tc, done, busy
   );

   modport slave (
      input  en, clr, load, load_val, start, dir, mode, limit, prescale,
      output out, tc, done, busy
   );
endinterface

// File: rtl/prog_counter.sv
// Programmable event counter: prescaled up/down count with wrap, saturate and one-shot terminal behaviours.
module prog_counter #(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   prog_counter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] M_SAT     = 2'b01;
   localparam logic [1:0] M_ONESHOT = 2'b10;

   logic [WIDTH-1:0]      out_q, out_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic                  tc_q, tc_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  sat_q, sat_d;
   state_t                state_q, state_d;

   logic tick;
   logic terminal;
   logic oneshot;

   function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v, input logic down);
      step_val = down ? (v - 1'b1) : (v + 1'b1);
   endfunction

   function automatic logic [WIDTH-1:0] reload_val(input logic [WIDTH-1:0] lim, input logic down);
      reload_val = down ? lim : '0;
   endfunction

   always_comb begin
      tick     = bus.en && (pcnt_q == bus.prescale);
      terminal = bus.dir ? (out_q == '0) : (out_q >= bus.limit);
      oneshot  = (bus.mode == M_ONESHOT);

      out_d   = out_q;
      pcnt_d  = pcnt_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      busy_d  = busy_q;
      sat_d   = sat_q;
      state_d = state_q;

      if (bus.en) begin
         pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      end

      if (bus.clr) begin
         out_d   = '0;
         pcnt_d  = '0;
         sat_d   = 1'b0;
         done_d  = 1'b0;
         busy_d  = 1'b0;
         state_d = S_IDLE;
      end else if (bus.load) begin
         out_d  = bus.load_val;
         pcnt_d = '0;
         sat_d  = 1'b0;
      end else if (bus.start && oneshot) begin
         // start reloads from any one-shot state, including a restart mid-run
         out_d   = reload_val(bus.limit, bus.dir);
         pcnt_d  = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         state_d = S_RUN;
      end else if (tick) begin
         if (oneshot) begin
            if (state_q == S_RUN) begin
               if (terminal) begin
                  tc_d    = 1'b1;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  out_d = step_val(out_q, bus.dir);
                  sat_d = 1'b0;
               end
            end
         end else if (!terminal) begin
            out_d = step_val(out_q, bus.dir);
            sat_d = 1'b0;
         end else if (bus.mode == M_SAT) begin
            // hold at the terminal value; only the first terminal tick pulses tc
            if (!sat_q) begin
               tc_d  = 1'b1;
               sat_d = 1'b1;
            end
         end else begin
            out_d = reload_val(bus.limit, bus.dir);
            tc_d  = 1'b1;
         end
      end

      if (!oneshot) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= '0;
         pcnt_q  <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         sat_q   <= 1'b0;
         state_q <= S_IDLE;
      end else begin
         out_q   <= out_d;
         pcnt_q  <= pcnt_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         sat_q   <= sat_d;
         state_q <= state_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.tc   = tc_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_prog_counter.sv
// Randomized and directed bench for prog_counter against a behavioural reference model.
module tb_prog_counter;

   localparam int W   = 16;
   localparam int PW  = 8;
   localparam int MOD = 1 << W;

   logic clk;
   logic rst;

   prog_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

   prog_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // reference model state: one-shot phase is just "running" plus the done flag
   int m_out, m_pcnt;
   bit m_tc, m_done, m_run, m_sat;
   int tc_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_pcnt = 0; m_tc = 0; m_done = 0; m_run = 0; m_sat = 0;
   endtask

   task automatic model_step();
      bit tick, term, os;
      int lim;
      tick = bus.en && (m_pcnt == int'(bus.prescale));
      lim  = int'(bus.limit);
      os   = (bus.mode == 2'b10);
      term = bus.dir ? (m_out == 0) : (m_out >= lim);
      m_tc = 0;
      if (bus.en) m_pcnt = tick ? 0 : m_pcnt + 1;
      if (bus.clr) begin
         m_out = 0; m_pcnt = 0; m_sat = 0; m_done = 0; m_run = 0;
      end else if (bus.load) begin
         m_out = int'(bus.load_val); m_pcnt = 0; m_sat = 0;
      end else if (bus.start && os) begin
         m_out = bus.dir ? lim : 0; m_pcnt = 0; m_run = 1; m_done = 0;
      end else if (tick) begin
         if (os) begin
            if (m_run) begin
               if (term) begin
                  m_tc = 1; m_done = 1; m_run = 0;
               end else begin
                  m_out = bus.dir ? (m_out + MOD - 1) % MOD : (m_out + 1) % MOD;
                  m_sat = 0;
               end
            end
         end else if (!term) begin
            m_out = bus.dir ? (m_out + MOD - 1) % MOD : (m_out + 1) % MOD;
            m_sat = 0;
         end else if (bus.mode == 2'b01) begin
            if (!m_sat) begin
               m_tc = 1; m_sat = 1;
            end
         end else begin
            m_out = bus.dir ? lim : 0;
            m_tc  = 1;
         end
      end
      if (!os) m_run = 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
      #1;
      chk("out",  32'(bus.out),  32'(m_out));
      chk("tc",   32'(bus.tc),   32'(m_tc));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("busy", 32'(bus.busy), 32'(m_run));
      if (bus.tc) tc_cnt++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      int pre_exp[6];
      rst = 1'b0;
      bus.en = 0; bus.clr = 0; bus.load = 0; bus.load_val = '0; bus.start = 0;
      bus.dir = 0; bus.mode = 2'b00; bus.limit = '0; bus.prescale = '0;
      model_reset();
      run(2);
      chk("rst_out", 32'(bus.out), 32'h0);
      chk("rst_flags", 32'({bus.tc, bus.done, bus.busy}), 32'h0);
      rst = 1'b1;

      // wrap across the full 16-bit range
      bus.limit = 16'hFFFF; bus.en = 1;
      tc_cnt = 0;
      for (int i = 0; i < 65537; i++) begin
         cycle();
         if (i == 65534) chk("wrap_ffff", 32'(bus.out), 32'hFFFF);
         if (i == 65535) chk("wrap_zero", 32'({bus.tc, bus.out}), 32'h10000);
      end
      chk("wrap_tc_count", 32'(tc_cnt), 32'd1);

      // async reset mid-count, no clock edge needed
      run(5);
      #2 rst = 1'b0;
      #1 chk("async_out", 32'(bus.out), 32'h0);
      model_reset();
      cycle();
      rst = 1'b1;

      // prescaler, down counting
      bus.prescale = 8'd3; bus.dir = 1; bus.limit = 16'd5; bus.mode = 2'b00;
      pre_exp = '{5, 4, 3, 2, 1, 0};
      for (int i = 1; i <= 24; i++) begin
         cycle();
         if (i % 4 == 0) chk("presc_out", 32'(bus.out), 32'(pre_exp[i/4 - 1]));
         if (i == 4) chk("presc_tc", 32'(bus.tc), 32'h1);
      end
      bus.en = 0;
      run(10);
      chk("freeze_out", 32'(bus.out), 32'h0);
      bus.en = 1;
      run(3);
      chk("freeze_pcnt", 32'(bus.out), 32'h0);
      cycle();
      chk("resume_wrap", 32'({bus.tc, bus.out}), 32'h10005);

      // saturate
      bus.clr = 1; cycle(); bus.clr = 0;
      bus.mode = 2'b01; bus.dir = 0; bus.limit = 16'd10; bus.prescale = 8'd0;
      tc_cnt = 0;
      run(15);
      chk("sat_out", 32'(bus.out), 32'd10);
      chk("sat_tc_count", 32'(tc_cnt), 32'd1);
      bus.dir = 1;
      run(3);
      chk("sat_down", 32'(bus.out), 32'd7);
      bus.dir = 0; tc_cnt = 0;
      run(6);
      chk("sat_again", 32'(bus.out), 32'd10);
      chk("sat_tc_again", 32'(tc_cnt), 32'd1);

      // one-shot
      bus.mode = 2'b10; bus.limit = 16'd7;
      bus.start = 1; cycle(); bus.start = 0;
      chk("os_start", 32'({bus.busy, bus.out}), 32'h10000);
      run(7);
      chk("os_at_limit", 32'(bus.out), 32'd7);
      cycle();
      chk("os_term", 32'({bus.tc, bus.done, bus.busy}), 32'b110);
      run(3);
      chk("os_hold", 32'({bus.done, bus.out}), 32'h10007);
      bus.start = 1; cycle(); bus.start = 0;
      run(4);
      chk("os_mid", 32'(bus.out), 32'd4);
      bus.start = 1; cycle(); bus.start = 0;
      chk("os_restart", 32'({bus.busy, bus.out}), 32'h10000);
      run(10);

      // priority
      bus.mode = 2'b00; bus.limit = 16'd100; bus.en = 1;
      bus.clr = 1; bus.load = 1; bus.load_val = 16'h1234; cycle();
      chk("pri_clr", 32'(bus.out), 32'h0);
      bus.clr = 0; cycle();
      chk("pri_load", 32'(bus.out), 32'h1234);
      bus.load_val = 16'd20; bus.limit = 16'd10; cycle(); bus.load = 0;
      cycle();
      chk("pri_above", 32'({bus.tc, bus.out}), 32'h10000);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bus.en    = ($urandom % 4) != 0;
         bus.clr   = ($urandom % 64) == 0;
         bus.load  = ($urandom % 32) == 0;
         bus.load_val = (($urandom % 8) == 0) ? 16'($urandom) : 16'($urandom_range(0, 30));
         bus.start = ($urandom % 16) == 0;
         if (($urandom % 20) == 0) bus.dir = ~bus.dir;
         if (($urandom % 50) == 0) bus.mode = 2'($urandom);
         if (($urandom % 40) == 0) bus.limit = 16'($urandom_range(0, 25));
         if (($urandom % 60) == 0) bus.prescale = 8'($urandom_range(0, 3));
         rst = ($urandom % 500) != 0;
         cycle();
      end
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised, programmable event counter; the next generation of the 16-bit free-running counter used for cycle/instruction counting and timers around the MIPS core.
- Adds a clock-enable prescaler, up/down direction, synchronous clear and parallel load, and a programmable terminal value.
- Three terminal behaviours: wrap, saturate, and one-shot (FSM-controlled).
- Drives a terminal-count pulse and status flags for the CPU's timer/perf-counter logic.

Parameters:
- WIDTH, 16, counter width in bits (≥2).
- PRESCALE_W, 8, prescaler divide-register width in bits (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; gates the prescaler.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- start  in  1  one-shot start/restart strobe.
- dir  in  1  0 = up, 1 = down.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- limit  in  WIDTH  terminal value, up direction, and reload value, down direction.
- prescale  in  PRESCALE_W  tick every prescale+1 enabled cycles.
- out  out  WIDTH  counter value, registered.
- tc  out  1  one-cycle terminal-count pulse, registered.
- done  out  1  one-shot complete, sticky.
- busy  out  1  one-shot running.

Behaviour:
- Reset (rst=0, async): out=0, tc=0, done=0, busy=0, prescaler pcnt=0, sat flag=0, FSM=IDLE. Release is synchronous to clk.
- Prescaler:
  - en=1 and pcnt==prescale → tick asserted this cycle, pcnt<=0.
  - en=1 otherwise → pcnt<=pcnt+1.
  - en=0 → pcnt holds, no tick.
  - prescale=0 → tick on every enabled cycle.
- Priority per cycle: rst > clr > load > start > tick.
  - clr: out<=0, pcnt<=0, sat<=0, done<=0, FSM<=IDLE.
  - load: out<=load_val, pcnt<=0, sat<=0; FSM state unchanged.
- tc: defaults to 0 every cycle; set only as listed below. Latency: tick in cycle N → out/tc updated at edge ending N; visible in cycle N+1.
- Terminal tick: a tick where (dir=0 and out>=limit) or (dir=1 and out==0). Using >= means a load above limit terminates on the next up tick.
- Non-terminal tick: out<=out+1 (up) or out-1 (down), modulo 2^WIDTH; sat<=0.
- WRAP (00/11), terminal tick: out<=0 (up) or limit (down); tc<=1.
  - limit=0 counting up: out stays 0, tc pulses every tick.
- SAT (01), terminal tick: out holds.
  - sat=0 → tc<=1, sat<=1.
  - sat=1 → no tc.
  - Flipping dir makes the next tick non-terminal, so counting resumes and sat clears.
- ONESHOT (10) FSM:
  - IDLE: out holds, ticks ignored. On start: out<=0 (up) or limit (down), pcnt<=0, busy<=1, done<=0, → RUN.
  - RUN: non-terminal ticks count. Terminal tick: out holds, tc<=1, done<=1, busy<=0, → DONE.
  - DONE: out holds. On start: reload as in IDLE, → RUN. clr → IDLE.
  - start while in RUN: restarts (reload, pcnt<=0), stays RUN.
  - load during RUN: out updated, stays RUN, busy stays 1.
- Mode ≠10: FSM forced to IDLE, busy<=0; done holds until clr or the next one-shot start.
- limit, prescale, dir and mode are sampled every cycle with no shadowing. Changes mid-count take effect on the next tick or compare.
- Reset asserted mid-operation: immediate return to reset values with no clock required.

Test Plan:
- Reset/wrap: WIDTH=16, prescale=0, mode=00, limit=16'hFFFF, en=1 for 65537 cycles → out reaches FFFF, then 0000; exactly one tc pulse, in the cycle out shows 0000; rst low mid-count → out=0 asynchronously.
- Prescaler/down: prescale=3, dir=1, limit=5, mode=00, en=1 → out decrements once per 4 cycles: 0→5 wrap with tc, then 4,3,2,1,0; en low for 10 cycles → out and pcnt frozen.
- Saturate: mode=01, dir=0, limit=10, prescale=0 → out stops at 10; single tc on the first terminal tick; dir=1 → out 9,8,…; back to up → new single tc at 10.
- One-shot: mode=10, limit=7, start pulse → busy=1, out 0…7, then tc+done on the terminal tick, busy=0, out holds 7; start in DONE → out=0, RUN; start mid-RUN at out=4 → out=0.
- Priority: clr, load (load_val=0x1234) and tick in the same cycle → out=0; load+tick → out=0x1234; load_val=20 with limit=10, up, wrap → next tick is terminal: out=0, tc=1.
